bram_wnd_reader: RTL and testbench

- Downstream consumer of the greyscale line buffer filled by the pixel-conversion stage. That buffer holds NLINES circular lines of HRES pixels, each a 16-bit word with grey in bits [7:0].
- Reads the BRAM's second port and emits one vertical NLINES-pixel column per transfer on a valid/ready stream, left to right, for the next filter/window stage.
- Pulses pixel_ack once per completed output row so the upstream stage refills exactly one line.

---
 rtl/bram_wnd_reader.sv | 182 ++++++++++++++++++
 tb/tb_bram_wnd_reader.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/bram_wnd_reader.sv
// bram_wnd_reader: streams NLINES-tall pixel columns out of a circular greyscale BRAM line buffer
// Ports: clk, rst_n (async, active-low); wnd_in_bram = full window resident;
//   bram_rd_addr/bram_rd_en/bram_rd_data = BRAM read port (1-cycle latency, grey in [7:0]);
//   col_data/col_valid/col_ready/col_x = column stream (lane k = line base+k, oldest in lane 0);
//   pixel_ack = row consumed pulse; frame_done = last-row-of-frame pulse.
// Define BRAM_WND_RD_SKID_EN for a 2-entry output FIFO that overlaps BRAM reads with output stalls.
module bram_wnd_reader #(
  parameter int HRES = 640,
  parameter int VRES = 480,
  parameter int NLINES = 8,
  parameter int ADDR_W = 13
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                wnd_in_bram,
  output logic [ADDR_W-1:0]   bram_rd_addr,
  output logic                bram_rd_en,
  input  logic [15:0]         bram_rd_data,
  output logic [8*NLINES-1:0] col_data,
  output logic                col_valid,
  input  logic                col_ready,
  output logic [9:0]          col_x,
  output logic                pixel_ack,
  output logic                frame_done
);
  localparam int KW = NLINES > 1 ? $clog2(NLINES) : 1;
  localparam int RW = $clog2(VRES + 1);
  localparam logic [ADDR_W-1:0] STEP = ADDR_W'(HRES);
  localparam logic [ADDR_W-1:0] TOP = ADDR_W'((NLINES - 1) * HRES);
  localparam logic [9:0] XMAX = 10'(HRES - 1);
`ifdef BRAM_WND_RD_SKID_EN
  typedef enum logic [2:0] {IDLE, WAIT_WND, READ, HOLD, DRAIN, ACK} state_t;
`else
  typedef enum logic [2:0] {IDLE, WAIT_WND, READ, LAST, OUT, ACK} state_t;
`endif
  state_t state_q, state_d;
  logic [9:0] x_q, x_d;
  logic [KW-1:0] k_q, k_d, rk_q;
  logic [ADDR_W-1:0] lb_q, lb_d, row_base_q, row_base_d;
  logic [RW-1:0] out_row_q, out_row_d;
  logic rd_q;
  logic [8*NLINES-1:0] col_q;
  logic last_k, row_end, unused_hi;
  // line_base advances one line per step and wraps at NLINES*HRES, so no multiplier is needed
  function automatic logic [ADDR_W-1:0] next_line(input logic [ADDR_W-1:0] lb);
    return lb == TOP ? '0 : lb + STEP;
  endfunction
  assign last_k = k_q == KW'(NLINES - 1);
  assign row_end = out_row_q == RW'(VRES - NLINES);
  assign bram_rd_en = state_q == READ;
  assign bram_rd_addr = bram_rd_en ? lb_q + ADDR_W'(x_q) : '0;
  assign pixel_ack = state_q == ACK;
  assign frame_done = pixel_ack && row_end;
  assign unused_hi = ^bram_rd_data[15:8];
`ifdef BRAM_WND_RD_SKID_EN
  // rsv_q counts columns started but not yet accepted, so a column only starts when a FIFO slot is guaranteed
  logic [1:0] rsv_q, cnt_q;
  logic wp_q, rp_q, start, push, pop, room;
  logic [8*NLINES-1:0] fd_q [2];
  logic [9:0] fx_q [2];
  logic [9:0] rx_q;
  assign pop = col_valid && col_ready;
  assign push = rd_q && rk_q == KW'(NLINES - 1);
  assign room = rsv_q < 2'd2 || pop;
  assign col_valid = cnt_q != '0;
  assign col_data = fd_q[rp_q];
  assign col_x = fx_q[rp_q];
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      rsv_q <= '0;
      cnt_q <= '0;
      wp_q <= 1'b0;
      rp_q <= 1'b0;
      rx_q <= '0;
      fd_q <= '{default: '0};
      fx_q <= '{default: '0};
    end else begin
      rsv_q <= rsv_q + {1'b0, start} - {1'b0, pop};
      cnt_q <= cnt_q + {1'b0, push} - {1'b0, pop};
      rx_q <= x_q;
      if (push) begin
        fd_q[wp_q] <= {bram_rd_data[7:0], col_q[8*NLINES-9:0]};
        fx_q[wp_q] <= rx_q;
        wp_q <= ~wp_q;
      end
      if (pop) rp_q <= ~rp_q;
    end
`else
  assign col_valid = state_q == OUT;
  assign col_data = col_q;
  assign col_x = x_q;
`endif
  always_comb begin
    state_d = state_q;
    x_d = x_q;
    k_d = k_q;
    lb_d = lb_q;
    row_base_d = row_base_q;
    out_row_d = out_row_q;
`ifdef BRAM_WND_RD_SKID_EN
    start = 1'b0;
`endif
    case (state_q)
      IDLE: state_d = WAIT_WND;
      WAIT_WND: if (wnd_in_bram) begin
        state_d = READ;
        x_d = '0;
        k_d = '0;
        lb_d = row_base_q;
`ifdef BRAM_WND_RD_SKID_EN
        start = 1'b1;
`endif
      end
      READ: begin
        k_d = k_q + 1'b1;
        lb_d = next_line(lb_q);
`ifdef BRAM_WND_RD_SKID_EN
        if (last_k) begin
          if (x_q == XMAX) state_d = DRAIN;
          else if (room) begin
            start = 1'b1;
            x_d = x_q + 1'b1;
            k_d = '0;
            lb_d = row_base_q;
          end else state_d = HOLD;
        end
`else
        if (last_k) state_d = LAST;
`endif
      end
`ifdef BRAM_WND_RD_SKID_EN
      HOLD: if (room) begin
        start = 1'b1;
        state_d = READ;
        x_d = x_q + 1'b1;
        k_d = '0;
        lb_d = row_base_q;
      end
      DRAIN: if (rsv_q == '0) state_d = ACK;
`else
      LAST: state_d = OUT;
      OUT: if (col_ready) begin
        if (x_q != XMAX) begin
          state_d = READ;
          x_d = x_q + 1'b1;
          k_d = '0;
          lb_d = row_base_q;
        end else state_d = ACK;
      end
`endif
      ACK: begin
        out_row_d = row_end ? '0 : out_row_q + 1'b1;
        row_base_d = row_end ? '0 : next_line(row_base_q);
        state_d = row_end ? IDLE : WAIT_WND;
      end
      default: state_d = IDLE;
    endcase
  end
  // data returns one cycle after issue, so the lane index travels with the read-valid flag
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= IDLE;
      x_q <= '0;
      k_q <= '0;
      rk_q <= '0;
      lb_q <= '0;
      row_base_q <= '0;
      out_row_q <= '0;
      rd_q <= 1'b0;
      col_q <= '0;
    end else begin
      state_q <= state_d;
      x_q <= x_d;
      k_q <= k_d;
      rk_q <= k_q;
      lb_q <= lb_d;
      row_base_q <= row_base_d;
      out_row_q <= out_row_d;
      rd_q <= bram_rd_en;
      if (rd_q) col_q[8*rk_q +: 8] <= bram_rd_data[7:0];
    end
endmodule

// File: tb/tb_bram_wnd_reader.sv
// tb_bram_wnd_reader: randomized self-checking bench for bram_wnd_reader against a behavioural column model
module tb_bram_wnd_reader;
  localparam int H = 64, V = 17, N = 8, AW = 13, ROWS = V - N + 1;
  logic clk = 1'b0, rst_n = 1'b0, wnd_in_bram = 1'b0, col_ready = 1'b1;
  logic [AW-1:0] bram_rd_addr;
  logic bram_rd_en;
  logic [15:0] bram_rd_data = '0;
  logic [8*N-1:0] col_data;
  logic col_valid;
  logic [9:0] col_x;
  logic pixel_ack, frame_done;
  logic [15:0] mem [N*H];
  int checks = 0, failures = 0, cyc = 0, acks = 0, frames = 0, rdy_mode = 1;
  int exp_x = 0, base = 0, rowf = 0, rd_cnt = 0;
  logic pv = 1'b0;
  logic [8*N-1:0] pd = '0;
  logic [9:0] px = '0;

  bram_wnd_reader #(.HRES(H), .VRES(V), .NLINES(N), .ADDR_W(AW)) dut (
    .clk(clk), .rst_n(rst_n), .wnd_in_bram(wnd_in_bram),
    .bram_rd_addr(bram_rd_addr), .bram_rd_en(bram_rd_en), .bram_rd_data(bram_rd_data),
    .col_data(col_data), .col_valid(col_valid), .col_ready(col_ready), .col_x(col_x),
    .pixel_ack(pixel_ack), .frame_done(frame_done));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) if (bram_rd_en) bram_rd_data <= mem[bram_rd_addr];

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // expected column: lane k holds line (base+k) mod N at column x
  function automatic logic [8*N-1:0] exp_col(input int b, input int x);
    logic [8*N-1:0] c;
    c = '0;
    for (int k = 0; k < N; k++) c[8*k +: 8] = mem[((b + k) % N) * H + x][7:0];
    return c;
  endfunction

  initial forever begin
    @(posedge clk);
    #1 col_ready = rdy_mode == 2 ? ($urandom_range(0, 3) != 0) : (rdy_mode == 1);
  end

  always @(negedge clk) begin
    if (!rst_n) begin
      exp_x = 0; base = 0; rowf = 0; rd_cnt = 0; pv = 1'b0;
    end else begin
      if (bram_rd_en) begin
        rd_cnt++;
        chk("rd_addr_range", 64'(bram_rd_addr < AW'(N * H)), 64'(1'b1));
      end
      if (pv) begin
        chk("hold_valid", 64'(col_valid), 64'(1'b1));
        chk("hold_data", col_data, pd);
        chk("hold_x", 64'(col_x), 64'(px));
      end
      if (col_valid && col_ready) begin
        chk("col_x", 64'(col_x), 64'(exp_x));
        chk("col_data", col_data, exp_col(base, exp_x));
        exp_x++;
      end
      if (pixel_ack) begin
        rowf++;
        acks++;
        chk("row_cols", 64'(exp_x), 64'(H));
        chk("row_reads", 64'(rd_cnt), 64'(N * H));
        chk("frame_done", 64'(frame_done), 64'(rowf == ROWS));
        if (rowf == ROWS) begin rowf = 0; base = 0; frames++; end
        else base = (base + 1) % N;
        exp_x = 0;
        rd_cnt = 0;
      end else if (frame_done) chk("frame_done_alone", 64'(frame_done), 64'(pixel_ack));
      pv = col_valid && !col_ready;
      pd = col_data;
      px = col_x;
    end
  end

  initial begin
    logic any;
    int t0, n, a0;
    for (int a = 0; a < N * H; a++)
      mem[a] = {8'($urandom), (a % H < 16) ? 8'((a / H) * 16 + a % H) : 8'($urandom)};
    repeat (3) @(negedge clk);
    chk("rst_rd_en", 64'(bram_rd_en), 64'(1'b0));
    chk("rst_valid", 64'(col_valid), 64'(1'b0));
    chk("rst_data", col_data, 64'h0);
    chk("rst_ack", 64'(pixel_ack | frame_done), 64'(1'b0));
    @(posedge clk);
    #1 rst_n = 1'b1;
    any = 1'b0;
    repeat (50) begin
      @(negedge clk);
      any = any | bram_rd_en | col_valid | pixel_ack | frame_done;
    end
    chk("idle_quiet", 64'(any), 64'(1'b0));
    @(posedge clk);
    #1 wnd_in_bram = 1'b1;
    for (int i = 0; i < 20 && !bram_rd_en; i++) @(negedge clk);
    t0 = cyc;
    for (int k = 0; k < N; k++) begin
      chk("first_rd_en", 64'(bram_rd_en), 64'(1'b1));
      chk("first_addr", 64'(bram_rd_addr), 64'(k * H));
      @(negedge clk);
    end
    for (int i = 0; i < 20 && !col_valid; i++) @(negedge clk);
    chk("latency", 64'(cyc - t0), 64'(9));
    chk("first_x", 64'(col_x), 64'(0));
    chk("first_col", col_data, 64'h7060504030201000);
    for (int i = 0; i < 5000 && acks < 1; i++) @(negedge clk);
    chk("row1_ack", 64'(acks), 64'(1));
    for (int i = 0; i < 50 && !col_valid; i++) @(negedge clk);
    chk("row2_x", 64'(col_x), 64'(0));
    chk("row2_col", col_data, 64'h0070605040302010);
    for (int i = 0; i < 2000 && !(col_valid && col_x == 20); i++) @(negedge clk);
    chk("stall_reach", 64'(col_x), 64'(20));
    rdy_mode = 0;
    repeat (10) @(negedge clk);
    n = 0;
    repeat (10) begin
      @(negedge clk);
      n += int'(bram_rd_en);
    end
    chk("stall_valid", 64'(col_valid), 64'(1'b1));
    chk("stall_reads", 64'(n), 64'(0));
    rdy_mode = 2;
    for (int i = 0; i < 40000 && frames < 1; i++) @(negedge clk);
    chk("frame1_acks", 64'(acks), 64'(ROWS));
    chk("frame1_done", 64'(frames), 64'(1));
    for (int i = 0; i < 40000 && frames < 2; i++) @(negedge clk);
    chk("frame2_acks", 64'(acks), 64'(2 * ROWS));
    for (int i = 0; i < 3000 && !(col_valid && col_x == 30); i++) @(negedge clk);
    chk("rst_reach", 64'(col_x), 64'(30));
    a0 = acks;
    #1 rst_n = 1'b0;
    #1;
    chk("mid_rst_rd_en", 64'(bram_rd_en), 64'(1'b0));
    chk("mid_rst_valid", 64'(col_valid), 64'(1'b0));
    chk("mid_rst_x", 64'(col_x), 64'(0));
    chk("mid_rst_data", col_data, 64'h0);
    chk("mid_rst_ack", 64'(pixel_ack | frame_done), 64'(1'b0));
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    rdy_mode = 1;
    for (int i = 0; i < 100 && !col_valid; i++) @(negedge clk);
    chk("restart_x", 64'(col_x), 64'(0));
    chk("restart_col", col_data, 64'h7060504030201000);
    for (int i = 0; i < 5000 && acks < a0 + 1; i++) @(negedge clk);
    chk("restart_ack", 64'(acks), 64'(a0 + 1));
    chk("restart_frames", 64'(frames), 64'(2));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1000000;
    failures++;
    $display("FAIL watchdog expired");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end
endmodule
